// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache/main-memory slice: default widths, responder FSM
// states and the closed-form initial memory contents.
package cache_mem_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int LATENCY_DEF    = 8;
  localparam logic [31:0] INIT_XOR_DEF = 32'hC0DE_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Power-on content of word a; benches use it to predict unwritten words.
  function automatic logic [31:0] init_word(input logic [31:0] a,
                                            input logic [31:0] init_xor = INIT_XOR_DEF);
    return init_xor ^ a;
  endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response bus between the L2 refill/write-back path (master) and the
// main-memory responder (slave).
interface main_memory_responder_if
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_last;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, combinational read, filled at time 0
// with init_word so every unwritten location has a predictable value.
module mem_word_array
  import cache_mem_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_XOR = DATA_W'(INIT_XOR_DEF)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Content is not touched by reset; this fill is the only initialisation.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DATA_W'(init_word(32'(i), 32'(INIT_XOR)));
    end
  end

  always @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: accepts one line read or word write at a time, waits a
// fixed latency, then returns a registered burst (reads) or a single ack beat (writes).
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_WAIT  | access latency countdown in lat_cnt
//   ST_BURST | read beat on rsp_*, one per cycle until rsp_last
//   ST_WRITE | write ack beat on rsp_*, word already committed
module main_memory_responder
  import cache_mem_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                LINE_WORDS = LINE_WORDS_DEF,
  parameter int                LATENCY    = LATENCY_DEF,
  parameter logic [DATA_W-1:0] INIT_XOR   = DATA_W'(INIT_XOR_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  main_memory_responder_if.slave   bus,
  output logic                     busy
);

  localparam int BW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [LCW-1:0]    LAT_LOAD  = LCW'(LATENCY - 1);

  state_t            state;
  logic [LCW-1:0]    lat_cnt;
  logic [BW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              rsp_last_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ADDR_W-1:0] rsp_addr_q;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              lat_done;

  assign lat_done = (lat_cnt == '0);
  assign mem_addr = addr_q + ADDR_W'(beat_cnt);
  // Commit on the edge that enters ST_WRITE, so a reset during WAIT drops the write.
  assign mem_we   = rst && (state == ST_WAIT) && lat_done && we_q;

  mem_word_array #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_XOR (INIT_XOR)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_we ? bus.req_addr : (bus.req_addr & LINE_MASK);
            wdata_q     <= bus.req_wdata;
            lat_cnt     <= LAT_LOAD;
            beat_cnt    <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_done) begin
            rsp_valid_q <= 1'b1;
            if (we_q) begin
              rsp_last_q <= 1'b1;
              rsp_addr_q <= addr_q;
              rsp_data_q <= wdata_q;
              state      <= ST_WRITE;
            end else begin
              rsp_last_q <= (beat_cnt == LAST_BEAT);
              rsp_addr_q <= mem_addr;
              rsp_data_q <= mem_rdata;
              beat_cnt   <= beat_cnt + 1'b1;
              state      <= ST_BURST;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_BURST: begin
          if (rsp_last_q) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_last_q  <= (beat_cnt == LAST_BEAT);
            rsp_addr_q  <= mem_addr;
            rsp_data_q  <= mem_rdata;
            beat_cnt    <= beat_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: default instance (LATENCY 8, 4-beat lines) checked
// against a word-array reference model, plus a LATENCY 1 / single-beat instance.
module tb_main_memory_responder;

  localparam int LAT = 8;
  localparam int LW  = 4;

  logic clk;
  logic rst;
  logic busy;
  logic busy1;

  int errors = 0;
  int checks = 0;

  main_memory_responder_if #(.ADDR_W(11), .DATA_W(32)) mif ();
  main_memory_responder_if #(.ADDR_W(11), .DATA_W(32)) mif1 ();

  main_memory_responder #(
    .ADDR_W(11), .DATA_W(32), .LINE_WORDS(LW), .LATENCY(LAT), .INIT_XOR(32'hC0DE_0000)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (mif),
    .busy (busy)
  );

  main_memory_responder #(
    .ADDR_W(11), .DATA_W(32), .LINE_WORDS(1), .LATENCY(1), .INIT_XOR(32'hC0DE_0000)
  ) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (mif1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: what each word address should currently hold.
  logic [31:0] mdl [2048];

  typedef struct {
    bit          we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [10:0] exp_addr0;
    logic [31:0] exp_data0;
    logic [31:0] exp_datal;
  } vec_t;

  vec_t vecs[6];

  logic [10:0] fa, ra;
  logic [31:0] fd, ld, rd;
  bit          rw;
  int          g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (mif.req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(n), 32'd0);
  endtask

  // Called at the sample point just after the accept edge.
  task automatic collect(input bit we, input logic [10:0] addr, input logic [31:0] wdata,
                         output logic [10:0] f_addr, output logic [31:0] f_data,
                         output logic [31:0] l_data);
    int          cyc = 0;
    int          n;
    logic [10:0] base;
    logic [10:0] ea;
    logic [31:0] ed;
    f_addr = '0;
    f_data = '0;
    l_data = '0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    while (mif.rsp_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(LAT));
    if (we) begin
      base = addr;
      n    = 1;
    end else begin
      base = 11'((int'(addr) / LW) * LW);
      n    = LW;
    end
    for (int i = 0; i < n; i++) begin
      ea = base + 11'(i);
      ed = we ? wdata : mdl[ea];
      if (i == 0) begin
        f_addr = mif.rsp_addr;
        f_data = mif.rsp_data;
      end
      chk("beat_valid", 32'(mif.rsp_valid), 32'd1);
      chk("beat_addr", 32'(mif.rsp_addr), 32'(ea));
      chk("beat_data", mif.rsp_data, ed);
      chk("beat_last", 32'(mif.rsp_last), 32'(i == n - 1));
      l_data = mif.rsp_data;
      step();
    end
    if (we) mdl[addr] = wdata;
    chk("bubble_valid", 32'(mif.rsp_valid), 32'd0);
    chk("bubble_last", 32'(mif.rsp_last), 32'd0);
    chk("bubble_ready", 32'(mif.req_ready), 32'd1);
    chk("hold_data", mif.rsp_data, l_data);
  endtask

  task automatic do_txn(input bit we, input logic [10:0] addr, input logic [31:0] wdata,
                        output logic [10:0] f_addr, output logic [31:0] f_data,
                        output logic [31:0] l_data);
    wait_ready();
    mif.req_valid = 1'b1;
    mif.req_we    = we;
    mif.req_addr  = addr;
    mif.req_wdata = wdata;
    step();
    mif.req_valid = 1'b0;
    collect(we, addr, wdata, f_addr, f_data, l_data);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mdl[i] = 32'hC0DE_0000 ^ 32'(i);

    vecs[0] = '{1'b0, 11'h123, 32'h0,         11'h120, 32'hC0DE_0120, 32'hC0DE_0123};
    vecs[1] = '{1'b1, 11'h7FF, 32'hDEAD_BEEF, 11'h7FF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 11'h7FD, 32'h0,         11'h7FC, 32'hC0DE_07FC, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 11'h041, 32'h1234_5678, 11'h041, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{1'b0, 11'h043, 32'h0,         11'h040, 32'hC0DE_0040, 32'hC0DE_0043};
    vecs[5] = '{1'b0, 11'h000, 32'h0,         11'h000, 32'hC0DE_0000, 32'hC0DE_0003};

    mif.req_valid  = 1'b0;
    mif.req_we     = 1'b0;
    mif.req_addr   = '0;
    mif.req_wdata  = '0;
    mif1.req_valid = 1'b0;
    mif1.req_we    = 1'b0;
    mif1.req_addr  = '0;
    mif1.req_wdata = '0;

    // Reset values
    rst = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(mif.req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(mif.rsp_valid), 32'd0);
    chk("rst_last", 32'(mif.rsp_last), 32'd0);
    chk("rst_data", mif.rsp_data, 32'd0);
    chk("rst_addr", 32'(mif.rsp_addr), 32'd0);
    chk("rst1_ready", 32'(mif1.req_ready), 32'd1);
    rst = 1'b1;
    step();

    // Directed table, including write-then-read at the top of memory
    for (int v = 0; v < 6; v++) begin
      do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, fa, fd, ld);
      chk("tbl_addr0", 32'(fa), 32'(vecs[v].exp_addr0));
      chk("tbl_data0", fd, vecs[v].exp_data0);
      chk("tbl_datal", ld, vecs[v].exp_datal);
    end

    // req_valid held across two reads; second request must wait for the bubble
    wait_ready();
    mif.req_valid = 1'b1;
    mif.req_we    = 1'b0;
    mif.req_addr  = 11'h300;
    step();
    mif.req_addr  = 11'h305;
    collect(1'b0, 11'h300, 32'h0, fa, fd, ld);
    chk("held_first_addr", 32'(fa), 32'h300);
    step();
    chk("held_accept_busy", 32'(busy), 32'd1);
    chk("held_accept_ready", 32'(mif.req_ready), 32'd0);
    mif.req_valid = 1'b0;
    collect(1'b0, 11'h305, 32'h0, fa, fd, ld);
    chk("held_second_addr", 32'(fa), 32'h304);

    // Reset in the middle of a read burst
    wait_ready();
    mif.req_valid = 1'b1;
    mif.req_we    = 1'b0;
    mif.req_addr  = 11'h200;
    step();
    mif.req_valid = 1'b0;
    g = 0;
    while (mif.rsp_valid !== 1'b1 && g < 100) begin
      step();
      g++;
    end
    step();
    step();
    chk("mid_beat_addr", 32'(mif.rsp_addr), 32'h202);
    rst = 1'b0;
    step();
    chk("abort_rd_valid", 32'(mif.rsp_valid), 32'd0);
    chk("abort_rd_ready", 32'(mif.req_ready), 32'd1);
    chk("abort_rd_busy", 32'(busy), 32'd0);
    chk("abort_rd_data", mif.rsp_data, 32'd0);
    rst = 1'b1;
    step();

    // Reset during WAIT of a write: the word must stay at its initial value
    wait_ready();
    mif.req_valid = 1'b1;
    mif.req_we    = 1'b1;
    mif.req_addr  = 11'h010;
    mif.req_wdata = 32'hAAAA_5555;
    step();
    mif.req_valid = 1'b0;
    step();
    step();
    step();
    chk("wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    chk("abort_wr_valid", 32'(mif.rsp_valid), 32'd0);
    chk("abort_wr_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();
    do_txn(1'b0, 11'h010, 32'h0, fa, fd, ld);
    chk("abort_wr_not_committed", fd, 32'hC0DE_0010);

    // Random traffic, biased into a small window so reads hit earlier writes
    for (int n = 0; n < 24; n++) begin
      rw = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) ra = 11'($urandom_range(0, 31));
      else ra = 11'($urandom);
      rd = $urandom;
      do_txn(rw, ra, rd, fa, fd, ld);
    end

    // LATENCY=1, LINE_WORDS=1 instance
    g = 0;
    while (mif1.req_ready !== 1'b1 && g < 50) begin
      step();
      g++;
    end
    mif1.req_valid = 1'b1;
    mif1.req_we    = 1'b0;
    mif1.req_addr  = 11'h005;
    step();
    mif1.req_valid = 1'b0;
    chk("l1_wait_valid", 32'(mif1.rsp_valid), 32'd0);
    chk("l1_wait_busy", 32'(busy1), 32'd1);
    step();
    chk("l1_beat_valid", 32'(mif1.rsp_valid), 32'd1);
    chk("l1_beat_last", 32'(mif1.rsp_last), 32'd1);
    chk("l1_beat_addr", 32'(mif1.rsp_addr), 32'h005);
    chk("l1_beat_data", mif1.rsp_data, 32'hC0DE_0005);
    step();
    chk("l1_after_valid", 32'(mif1.rsp_valid), 32'd0);
    chk("l1_after_ready", 32'(mif1.req_ready), 32'd1);

    mif1.req_valid = 1'b1;
    mif1.req_we    = 1'b1;
    mif1.req_addr  = 11'h006;
    mif1.req_wdata = 32'h1111_2222;
    step();
    mif1.req_valid = 1'b0;
    step();
    chk("l1_wack_valid", 32'(mif1.rsp_valid), 32'd1);
    chk("l1_wack_data", mif1.rsp_data, 32'h1111_2222);
    step();
    mif1.req_valid = 1'b1;
    mif1.req_we    = 1'b0;
    step();
    mif1.req_valid = 1'b0;
    step();
    chk("l1_rd_after_wr", mif1.rsp_data, 32'h1111_2222);
    chk("l1_rd_after_wr_last", 32'(mif1.rsp_last), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
